// File: rtl/sun_pll_fbdiv_lock.sv
// PLL feedback divider (CK -> CK_FB, glitch-free ratio changes at wrap) with a
// CK_REF period meter and lock detector.
//
// state | meaning
// IDLE  | no reference seen (or reference lost); first edge only re-arms the meter
// MEAS  | measuring CK_REF periods, counting consecutive in-tolerance results
// LOCK  | LOCK_CNT consecutive good periods seen; LOCKED asserted
module sun_pll_fbdiv_lock #(
    parameter int DIV_W    = 8,
    parameter int PER_W    = 10,
    parameter int DIV_RST  = 32,
    parameter int TOL      = 2,
    parameter int LOCK_CNT = 16
) (
    input  logic             CK,
    input  logic             PWRUP_1V8,
    input  logic [DIV_W-1:0] DIV_N,
    input  logic             CK_REF,
    output logic             CK_FB,
    output logic             LOCKED,
    output logic [PER_W-1:0] PER_CNT,
    output logic             PER_VALID
);

    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int CMP_W  = ((PER_W > DIV_W) ? PER_W : DIV_W) + 1;
    localparam logic [PER_W-1:0] PER_MAX = '1;

    typedef enum logic [1:0] {IDLE, MEAS, LOCK} state_t;

    state_t            state, state_n;
    logic [DIV_W-1:0]  cnt, n_sh, n_req;
    logic              wrap, n_chg;
    logic              s1, s2, s3, rise;
    logic [PER_W-1:0]  per_cnt;
    logic              sat, good_m, per_upd, locked_n;
    logic [CMP_W-1:0]  m_ext, n_ext, diff;
    logic [GOOD_W-1:0] good, good_n;

    // Ratio is only re-sampled at wrap so a period is never cut short.
    assign n_req = (DIV_N < DIV_W'(2)) ? DIV_W'(2) : DIV_N;
    assign wrap  = (cnt == n_sh - DIV_W'(1));
    assign n_chg = wrap && (n_req != n_sh);

    always_ff @(posedge CK or negedge PWRUP_1V8) begin
        if (!PWRUP_1V8) begin
            cnt   <= '0;
            n_sh  <= DIV_W'(DIV_RST);
            CK_FB <= 1'b0;
        end else begin
            CK_FB <= (cnt < (n_sh >> 1));
            if (wrap) begin
                cnt  <= '0;
                n_sh <= n_req;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CK or negedge PWRUP_1V8) begin
        if (!PWRUP_1V8) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            s3      <= 1'b0;
            per_cnt <= '0;
        end else begin
            s1 <= CK_REF;
            s2 <= s1;
            s3 <= s2;
            if (rise)
                per_cnt <= PER_W'(1);
            else if (!sat)
                per_cnt <= per_cnt + 1'b1;
        end
    end

    assign rise   = s2 & ~s3;
    assign sat    = (per_cnt == PER_MAX);
    assign m_ext  = CMP_W'(per_cnt);
    assign n_ext  = CMP_W'(n_sh);
    assign diff   = (m_ext >= n_ext) ? (m_ext - n_ext) : (n_ext - m_ext);
    assign good_m = !sat && (diff <= CMP_W'(TOL));

    // Priority: reference lost, then ratio change, then the period just measured.
    always_comb begin
        state_n  = state;
        good_n   = good;
        locked_n = LOCKED;
        per_upd  = rise && (state != IDLE);
        if (sat && (state != IDLE)) begin
            state_n  = IDLE;
            good_n   = '0;
            locked_n = 1'b0;
        end else if (n_chg) begin
            state_n  = MEAS;
            good_n   = '0;
            locked_n = 1'b0;
        end else if (rise) begin
            case (state)
                IDLE: begin
                    state_n = MEAS;
                    good_n  = '0;
                end
                MEAS: begin
                    if (good_m) begin
                        good_n = good + 1'b1;
                        if (good == GOOD_W'(LOCK_CNT - 1)) begin
                            state_n  = LOCK;
                            locked_n = 1'b1;
                        end
                    end else begin
                        good_n = '0;
                    end
                end
                LOCK: begin
                    if (!good_m) begin
                        state_n  = MEAS;
                        good_n   = '0;
                        locked_n = 1'b0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge CK or negedge PWRUP_1V8) begin
        if (!PWRUP_1V8) begin
            state     <= IDLE;
            good      <= '0;
            LOCKED    <= 1'b0;
            PER_CNT   <= '0;
            PER_VALID <= 1'b0;
        end else begin
            state     <= state_n;
            good      <= good_n;
            LOCKED    <= locked_n;
            PER_VALID <= per_upd;
            if (per_upd)
                PER_CNT <= per_cnt;
        end
    end

endmodule

// File: tb/tb_sun_pll_fbdiv_lock.sv
// Directed bench for sun_pll_fbdiv_lock: divider waveform, period meter,
// lock acquire/loss, reference loss and mid-run reset.
module tb_sun_pll_fbdiv_lock;

    logic       CK = 1'b0;
    logic       PWRUP_1V8 = 1'b0;
    logic [7:0] DIV_N = 8'd8;
    logic       CK_REF = 1'b0;
    logic       CK_FB, LOCKED, PER_VALID;
    logic [9:0] PER_CNT;

    int checks = 0;
    int errors = 0;
    int pv_seen, per_seen, n;

    sun_pll_fbdiv_lock dut (
        .CK        (CK),
        .PWRUP_1V8 (PWRUP_1V8),
        .DIV_N     (DIV_N),
        .CK_REF    (CK_REF),
        .CK_FB     (CK_FB),
        .LOCKED    (LOCKED),
        .PER_CNT   (PER_CNT),
        .PER_VALID (PER_VALID)
    );

    always #5 CK = ~CK;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CK);
        #1;
    endtask

    // Length of the current CK_FB run at level lvl; leaves us on the first sample of the next run.
    task automatic run_len(input logic lvl, output int len);
        len = 0;
        while (CK_FB === lvl && len < 200) begin
            len++;
            tick();
        end
    endtask

    // One CK_REF period of p CK cycles starting with a rising edge; records PER_VALID activity.
    task automatic ref_cycle(input int p);
        pv_seen  = 0;
        per_seen = -1;
        CK_REF   = 1'b1;
        for (int i = 0; i < p; i++) begin
            if (i == p / 2) CK_REF = 1'b0;
            tick();
            if (PER_VALID === 1'b1) begin
                pv_seen++;
                per_seen = int'(PER_CNT);
            end
        end
    endtask

    initial begin
        // 1: reset, release with DIV_N=8, reference idle
        repeat (3) @(posedge CK);
        #1;
        chk("rst_ck_fb", CK_FB, 0);
        chk("rst_locked", LOCKED, 0);
        chk("rst_per_cnt", PER_CNT, 0);
        chk("rst_per_valid", PER_VALID, 0);
        PWRUP_1V8 = 1'b1;
        chk("rel_ck_fb", CK_FB, 0);
        tick();
        chk("first_fb_high", CK_FB, 1);
        run_len(1'b1, n); chk("t1_hi32", n, 16);
        run_len(1'b0, n); chk("t1_lo32", n, 16);
        run_len(1'b1, n); chk("t1_hi8", n, 4);
        run_len(1'b0, n); chk("t1_lo8", n, 4);
        chk("t1_locked", LOCKED, 0);

        // 2: odd ratio, then a ratio change mid-period
        DIV_N = 8'd7;
        run_len(1'b1, n); chk("t2_hi8_tail", n, 4);
        run_len(1'b0, n); chk("t2_lo8_tail", n, 4);
        run_len(1'b1, n); chk("t2_hi7", n, 3);
        run_len(1'b0, n); chk("t2_lo7", n, 4);
        tick();
        tick();
        DIV_N = 8'd10;
        run_len(1'b1, n); chk("t2_hi7_rest", n, 1);
        run_len(1'b0, n); chk("t2_lo7_full", n, 4);
        run_len(1'b1, n); chk("t2_hi10", n, 5);
        run_len(1'b0, n); chk("t2_lo10", n, 5);

        // 3: acquire lock with period 8
        DIV_N = 8'd8;
        run_len(1'b1, n);
        run_len(1'b0, n);
        pv_seen = 0;
        repeat (1100) begin
            tick();
            if (PER_VALID === 1'b1) pv_seen++;
        end
        chk("t3_idle_no_pv", pv_seen, 0);
        ref_cycle(8);
        chk("t3_discard_pv", pv_seen, 0);
        for (int k = 1; k <= 16; k++) begin
            ref_cycle(8);
            chk("t3_pv", pv_seen, 1);
            chk("t3_per", per_seen, 8);
            chk("t3_lock", LOCKED, (k == 16) ? 1 : 0);
        end

        // 4: out-of-tolerance period drops lock; error of TOL keeps it
        ref_cycle(11);
        chk("t4_pre_per", per_seen, 8);
        chk("t4_pre_lock", LOCKED, 1);
        ref_cycle(8);
        chk("t4_per11", per_seen, 11);
        chk("t4_lock_lost", LOCKED, 0);
        for (int k = 1; k <= 16; k++) begin
            ref_cycle(8);
            chk("t4_relock", LOCKED, (k == 16) ? 1 : 0);
        end
        ref_cycle(10);
        ref_cycle(8);
        chk("t4_per10", per_seen, 10);
        chk("t4_keep10", LOCKED, 1);
        ref_cycle(6);
        ref_cycle(8);
        chk("t4_per6", per_seen, 6);
        chk("t4_keep6", LOCKED, 1);

        // 5: reference lost -> saturation -> IDLE
        n = 0;
        while (LOCKED === 1'b1 && n < 1200) begin
            tick();
            n++;
        end
        chk("t5_loss_latency", n, 1018);
        ref_cycle(8);
        chk("t5_resume_no_pv", pv_seen, 0);
        ref_cycle(8);
        chk("t5_pv", pv_seen, 1);
        chk("t5_per", per_seen, 8);
        for (int k = 1; k <= 15; k++) begin
            ref_cycle(8);
            chk("t5_relock", LOCKED, (k == 15) ? 1 : 0);
        end

        // 6: reset pulse while locked and CK_FB high
        n = 0;
        while (CK_FB !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("t6_pre_fb", CK_FB, 1);
        PWRUP_1V8 = 1'b0;
        #1;
        chk("t6_rst_fb", CK_FB, 0);
        chk("t6_rst_locked", LOCKED, 0);
        chk("t6_rst_per", PER_CNT, 0);
        chk("t6_rst_pv", PER_VALID, 0);
        @(posedge CK);
        #1;
        PWRUP_1V8 = 1'b1;
        chk("t6_rel_fb", CK_FB, 0);
        tick();
        chk("t6_first_high", CK_FB, 1);
        run_len(1'b1, n); chk("t6_hi32", n, 16);
        run_len(1'b0, n); chk("t6_lo32", n, 16);
        run_len(1'b1, n); chk("t6_hi8", n, 4);
        chk("t6_locked", LOCKED, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
